// File: rtl/tx_phy_framer.sv
// USB-PD TX framer: 4b5b symbols for [preamble if TX_PREAMBLE_EN], SOP K-codes, data nibbles, CRC32, EOP.
// Symbols valid the cycle after TX_START; stalls on SYM_READY low, one-cycle bubble per fetched byte.
module tx_phy_framer (
  input  logic       CLK,
  input  logic       reset,
  input  logic       TX_START,
  input  logic [2:0] TX_SOP_TYPE,
  input  logic [7:0] TX_BYTE_COUNT,
  input  logic [7:0] TX_DATA,
  input  logic       TX_DATA_VALID,
  output logic       TX_DATA_READY,
  input  logic       TX_ABORT,
  output logic [4:0] SYM_OUT,
  output logic       SYM_VALID,
  input  logic       SYM_READY,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERROR
);

  localparam logic [4:0] SYNC1 = 5'b11000;
  localparam logic [4:0] SYNC2 = 5'b10001;
  localparam logic [4:0] SYNC3 = 5'b00110;
  localparam logic [4:0] EOP_K = 5'b01101;

`ifdef TX_PREAMBLE_EN
  localparam int IDX_W = 4;
`else
  localparam int IDX_W = 3;
`endif

  typedef enum logic [2:0] {
    IDLE,
`ifdef TX_PREAMBLE_EN
    PREAMBLE,
`endif
    SOP,
    DATA_LO,
    DATA_HI,
    CRC,
    EOP
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [1:0]         sop_type;
  logic [4:0]         byte_cnt;
  logic [31:0]        crc;
  logic [7:0]         hold_dat;
  logic               hold_vld;
  logic               start_ok, abort_hit, sym_xfer, byte_acc;
  logic [31:0]        crc_out;

  function automatic logic [4:0] enc4b5b(input logic [3:0] n);
    logic [4:0] s;
    case (n)
      4'h0: s = 5'b11110;  4'h1: s = 5'b01001;  4'h2: s = 5'b10100;  4'h3: s = 5'b10101;
      4'h4: s = 5'b01010;  4'h5: s = 5'b01011;  4'h6: s = 5'b01110;  4'h7: s = 5'b01111;
      4'h8: s = 5'b10010;  4'h9: s = 5'b10011;  4'hA: s = 5'b10110;  4'hB: s = 5'b10111;
      4'hC: s = 5'b11010;  4'hD: s = 5'b11011;  4'hE: s = 5'b11100;  default: s = 5'b11101;
    endcase
    return s;
  endfunction

  function automatic logic [4:0] sop_sym(input logic [1:0] t, input logic [1:0] i);
    logic [4:0] s;
    case (t)
      2'd1:    s = i[1] ? SYNC3 : SYNC1;
      2'd2:    s = i[0] ? SYNC3 : SYNC1;
      default: s = (i == 2'd3) ? SYNC2 : SYNC1;
    endcase
    return s;
  endfunction

  // Reflected CRC32 (0x04C11DB7 reversed = 0xEDB88320), one byte per call.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign start_ok      = (TX_SOP_TYPE <= 3'd2) && (TX_BYTE_COUNT >= 8'd2) && (TX_BYTE_COUNT <= 8'd30);
  assign abort_hit     = (state != IDLE) && TX_ABORT;
  assign TX_BUSY       = (state != IDLE);
  assign TX_DATA_READY = (state == DATA_LO) && !hold_vld;
  assign SYM_VALID     = (state != IDLE) && !((state == DATA_LO) && !hold_vld);
  assign sym_xfer      = SYM_VALID && SYM_READY;
  assign byte_acc      = TX_DATA_READY && TX_DATA_VALID;
  assign crc_out       = ~crc;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    SYM_OUT   = 5'b00000;
    case (state)
      IDLE: begin
        if (TX_START && start_ok) begin
`ifdef TX_PREAMBLE_EN
          state_nxt = PREAMBLE;
`else
          state_nxt = SOP;
`endif
        end
      end
`ifdef TX_PREAMBLE_EN
      PREAMBLE: begin
        SYM_OUT = idx[0] ? 5'b10101 : 5'b01010;
        if (sym_xfer && idx == 4'd11) state_nxt = SOP;
      end
`endif
      SOP: begin
        SYM_OUT = sop_sym(sop_type, idx[1:0]);
        if (sym_xfer && idx == IDX_W'(3)) state_nxt = DATA_LO;
      end
      DATA_LO: begin
        SYM_OUT = enc4b5b(hold_dat[3:0]);
        if (sym_xfer) state_nxt = DATA_HI;
      end
      DATA_HI: begin
        SYM_OUT = enc4b5b(hold_dat[7:4]);
        if (sym_xfer) state_nxt = (byte_cnt == 5'd0) ? CRC : DATA_LO;
      end
      CRC: begin
        SYM_OUT = enc4b5b(crc_out[{idx[2:0], 2'b00} +: 4]);
        if (sym_xfer && idx == IDX_W'(7)) state_nxt = EOP;
      end
      EOP: begin
        SYM_OUT = EOP_K;
        if (sym_xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      sop_type <= 2'd0;
      byte_cnt <= 5'd0;
      crc      <= 32'hFFFFFFFF;
      hold_dat <= 8'h00;
      hold_vld <= 1'b0;
      TX_DONE  <= 1'b0;
      TX_ERROR <= 1'b0;
    end else begin
      TX_DONE  <= 1'b0;
      TX_ERROR <= 1'b0;
      if (abort_hit) begin
        TX_ERROR <= 1'b1;
        hold_vld <= 1'b0;
      end else begin
        if (state == IDLE && TX_START) begin
          if (start_ok) begin
            sop_type <= TX_SOP_TYPE[1:0];
            byte_cnt <= TX_BYTE_COUNT[4:0];
            crc      <= 32'hFFFFFFFF;
            idx      <= '0;
            hold_vld <= 1'b0;
          end else begin
            TX_ERROR <= 1'b1;
          end
        end
        if (byte_acc) begin
          hold_dat <= TX_DATA;
          hold_vld <= 1'b1;
          byte_cnt <= byte_cnt - 5'd1;
          crc      <= crc_byte(crc, TX_DATA);
        end
        if (sym_xfer) begin
          idx <= (state_nxt != state) ? '0 : idx + IDX_W'(1);
          if (state == DATA_HI) hold_vld <= 1'b0;
          if (state == EOP)     TX_DONE  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_phy_framer.sv
// Randomized scoreboard bench for tx_phy_framer: expected symbol stream from a reference model, monitor pops on each transfer.
module tb_tx_phy_framer;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       TX_START = 1'b0;
  logic [2:0] TX_SOP_TYPE = 3'd0;
  logic [7:0] TX_BYTE_COUNT = 8'd0;
  logic [7:0] TX_DATA = 8'd0;
  logic       TX_DATA_VALID = 1'b0;
  logic       TX_ABORT = 1'b0;
  logic       SYM_READY = 1'b1;
  logic       TX_DATA_READY, SYM_VALID, TX_BUSY, TX_DONE, TX_ERROR;
  logic [4:0] SYM_OUT;

  tx_phy_framer dut (
    .CLK(CLK), .reset(reset), .TX_START(TX_START), .TX_SOP_TYPE(TX_SOP_TYPE),
    .TX_BYTE_COUNT(TX_BYTE_COUNT), .TX_DATA(TX_DATA), .TX_DATA_VALID(TX_DATA_VALID),
    .TX_DATA_READY(TX_DATA_READY), .TX_ABORT(TX_ABORT), .SYM_OUT(SYM_OUT),
    .SYM_VALID(SYM_VALID), .SYM_READY(SYM_READY), .TX_BUSY(TX_BUSY),
    .TX_DONE(TX_DONE), .TX_ERROR(TX_ERROR)
  );

  always #5 CLK = ~CLK;

  localparam logic [4:0] ENC [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011,
                                      5'b01110, 5'b01111, 5'b10010, 5'b10011, 5'b10110, 5'b10111,
                                      5'b11010, 5'b11011, 5'b11100, 5'b11101};
  localparam logic [4:0] S1 = 5'b11000, S2 = 5'b10001, S3 = 5'b00110;
  localparam logic [4:0] SOP_TBL [3][4] = '{'{S1, S1, S1, S2}, '{S1, S1, S3, S3}, '{S1, S3, S1, S3}};

  int n_chk = 0, n_pass = 0;
  logic [4:0] exp_q[$];
  logic [7:0] cur_bytes[$];
  logic [7:0] byte_q[$];
  int  byte_idx = 0, gap_at = -1, gap_len = 0, gap_left = 0;
  int  rdy_low = 0, rdy_low_at = 0;
  bit  rand_rdy = 0, take = 0, hold_pending = 0;
  logic [4:0] hold_sym = 5'd0;
  int  done_cnt = 0, err_cnt = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_crc();
    logic [31:0] r;
    logic [31:0] o;
    logic [7:0]  rb;
    r = 32'hFFFFFFFF;
    foreach (cur_bytes[k]) begin
      for (int i = 0; i < 8; i++) rb[i] = cur_bytes[k][7-i];
      r = r ^ {rb, 24'h0};
      for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    end
    for (int i = 0; i < 32; i++) o[i] = r[31-i];
    return ~o;
  endfunction

  task automatic push_expected(input int typ);
    logic [31:0] c;
`ifdef TX_PREAMBLE_EN
    for (int i = 0; i < 12; i++) exp_q.push_back((i % 2) ? 5'b10101 : 5'b01010);
`endif
    for (int i = 0; i < 4; i++) exp_q.push_back(SOP_TBL[typ][i]);
    foreach (cur_bytes[k]) begin
      exp_q.push_back(ENC[cur_bytes[k][3:0]]);
      exp_q.push_back(ENC[cur_bytes[k][7:4]]);
    end
    c = ref_crc();
    for (int i = 0; i < 8; i++) exp_q.push_back(ENC[c[4*i +: 4]]);
    exp_q.push_back(5'b01101);
  endtask

  task automatic make_bytes(input int n);
    cur_bytes.delete();
    for (int i = 0; i < n; i++) cur_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  // Byte source: pops a byte the cycle after a handshake, optional gap after byte gap_at.
  always @(negedge CLK) take = TX_DATA_VALID && TX_DATA_READY && !reset;
  always @(posedge CLK) begin
    #1;
    if (take && byte_q.size() > 0) begin
      void'(byte_q.pop_front());
      byte_idx++;
      if (byte_idx == gap_at) gap_left = gap_len;
    end
    if (gap_left > 0) begin
      gap_left--;
      TX_DATA_VALID = 1'b0;
    end else begin
      TX_DATA_VALID = (byte_q.size() > 0);
    end
    TX_DATA = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
  end

  always @(posedge CLK) begin
    #1;
    if (rdy_low_at > 0 && exp_q.size() <= rdy_low_at) begin
      rdy_low = 5;
      rdy_low_at = 0;
    end
    if (rdy_low > 0) begin
      rdy_low--;
      SYM_READY = 1'b0;
    end else begin
      SYM_READY = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor
  always @(negedge CLK) begin
    if (reset) begin
      hold_pending = 0;
    end else begin
      if (TX_DONE)  done_cnt++;
      if (TX_ERROR) err_cnt++;
      if (hold_pending && SYM_VALID) cmp("sym_hold", SYM_OUT, hold_sym);
      hold_pending = SYM_VALID && !SYM_READY && !TX_ABORT;
      hold_sym = SYM_OUT;
      if (TX_DATA_READY) cmp("valid_while_fetch", SYM_VALID, 1'b0);
      if (SYM_VALID && SYM_READY && !TX_ABORT) begin
        if (exp_q.size() == 0) cmp("unexpected_sym", SYM_OUT, 5'h1F ^ SYM_OUT);
        else cmp("sym", SYM_OUT, exp_q.pop_front());
      end
    end
  end

  task automatic start_pulse(input logic [2:0] typ, input logic [7:0] cnt);
    @(posedge CLK); #1;
    TX_START = 1'b1; TX_SOP_TYPE = typ; TX_BYTE_COUNT = cnt;
    @(posedge CLK); #1;
    TX_START = 1'b0;
  endtask

  task automatic load_frame(input int typ, output int d0, output int e0);
    @(negedge CLK);
    byte_q = cur_bytes;
    byte_idx = 0;
    push_expected(typ);
    d0 = done_cnt;
    e0 = err_cnt;
  endtask

  task automatic run_frame(input int typ, input int busy_at);
    int d0, e0;
    bit seen, extra;
    seen = 0; extra = 0;
    load_frame(typ, d0, e0);
    start_pulse(3'(typ), 8'(cur_bytes.size()));
    @(negedge CLK);
    cmp("busy_after_start", TX_BUSY, 1'b1);
    cmp("valid_after_start", SYM_VALID, 1'b1);
    for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
      @(posedge CLK); #1;
      TX_START = 1'b0;
      if (busy_at > 0 && !extra && exp_q.size() <= busy_at) begin
        TX_START = 1'b1; TX_SOP_TYPE = 3'd0; TX_BYTE_COUNT = 8'd4; extra = 1;
      end
      @(negedge CLK);
      if (TX_DONE) seen = 1;
    end
    TX_START = 1'b0;
    cmp("tx_done", seen, 1'b1);
    cmp("syms_left", exp_q.size(), 0);
    cmp("no_err", err_cnt - e0, 0);
    @(negedge CLK);
    cmp("done_pulse_len", TX_DONE, 1'b0);
    cmp("idle_busy", TX_BUSY, 1'b0);
    cmp("done_cnt", done_cnt - d0, 1);
  endtask

  task automatic bad_start(input logic [2:0] typ, input logic [7:0] cnt);
    int e0;
    @(negedge CLK);
    e0 = err_cnt;
    start_pulse(typ, cnt);
    @(negedge CLK);
    cmp("err_pulse", TX_ERROR, 1'b1);
    cmp("err_busy", TX_BUSY, 1'b0);
    cmp("err_valid", SYM_VALID, 1'b0);
    @(negedge CLK);
    cmp("err_pulse_len", TX_ERROR, 1'b0);
    cmp("err_cnt", err_cnt - e0, 1);
  endtask

  task automatic abort_frame();
    int d0, e0;
    bit hit;
    hit = 0;
    make_bytes(6);
    load_frame(0, d0, e0);
    start_pulse(3'd0, 8'd6);
    for (int cyc = 0; cyc < 4000 && !hit; cyc++) begin
      @(negedge CLK);
      if (exp_q.size() <= 6) hit = 1;
    end
    cmp("abort_reach_crc", hit, 1'b1);
    @(posedge CLK); #1 TX_ABORT = 1'b1;
    @(posedge CLK); #1 TX_ABORT = 1'b0;
    @(negedge CLK);
    cmp("abort_valid", SYM_VALID, 1'b0);
    cmp("abort_err", TX_ERROR, 1'b1);
    cmp("abort_busy", TX_BUSY, 1'b0);
    repeat (5) @(negedge CLK);
    cmp("abort_no_done", done_cnt - d0, 0);
    cmp("abort_err_cnt", err_cnt - e0, 1);
    exp_q.delete();
  endtask

  task automatic reset_mid_frame();
    int d0, e0;
    bit hit;
    hit = 0;
    make_bytes(8);
    load_frame(1, d0, e0);
    start_pulse(3'd1, 8'd8);
    for (int cyc = 0; cyc < 4000 && !hit; cyc++) begin
      @(negedge CLK);
      if (exp_q.size() <= 12) hit = 1;
    end
    cmp("rst_reach_data", hit, 1'b1);
    @(posedge CLK); #1 reset = 1'b1;
    #1;
    cmp("rst_valid_now", SYM_VALID, 1'b0);
    cmp("rst_busy_now", TX_BUSY, 1'b0);
    @(negedge CLK);
    cmp("rst_done", TX_DONE, 1'b0);
    cmp("rst_err", TX_ERROR, 1'b0);
    @(negedge CLK);
    exp_q.delete();
    byte_q.delete();
    @(posedge CLK); #1 reset = 1'b0;
    repeat (4) @(negedge CLK);
    cmp("rst_no_done", done_cnt - d0, 0);
    cmp("rst_no_err", err_cnt - e0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int e0;
    repeat (3) @(negedge CLK);
    cmp("rst_sym_out", SYM_OUT, 5'd0);
    cmp("rst_sym_valid", SYM_VALID, 1'b0);
    cmp("rst_data_ready", TX_DATA_READY, 1'b0);
    cmp("rst_busy", TX_BUSY, 1'b0);
    cmp("rst_tx_done", TX_DONE, 1'b0);
    cmp("rst_tx_error", TX_ERROR, 1'b0);
    @(posedge CLK); #1 reset = 1'b0;

    cur_bytes = '{8'h41, 8'h00};
    run_frame(0, 0);

    rand_rdy = 1;
    make_bytes($urandom_range(2, 30)); run_frame(1, 0);
    make_bytes($urandom_range(2, 30)); run_frame(2, 0);

    bad_start(3'd0, 8'd31);
    bad_start(3'd3, 8'd5);
    bad_start(3'd0, 8'd1);
    bad_start(3'd1, 8'd0);

    @(negedge CLK); e0 = err_cnt;
    @(posedge CLK); #1 TX_ABORT = 1'b1;
    @(posedge CLK); #1 TX_ABORT = 1'b0;
    @(negedge CLK);
    cmp("idle_abort_err", TX_ERROR, 1'b0);
    cmp("idle_abort_busy", TX_BUSY, 1'b0);
    @(negedge CLK);
    cmp("idle_abort_cnt", err_cnt - e0, 0);

    make_bytes(10); rdy_low_at = 20; run_frame(0, 0);
    make_bytes(5); gap_at = 1; gap_len = 3; run_frame(1, 0); gap_at = -1;
    make_bytes(12); run_frame(2, 15);

    abort_frame();
    make_bytes(4); run_frame(0, 0);

    reset_mid_frame();
    for (int k = 0; k < 4; k++) begin
      make_bytes($urandom_range(2, 30));
      run_frame($urandom_range(0, 2), 0);
    end
    make_bytes(30); run_frame(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
